// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the parametrised binary-to-BCD converter.
// Holds the one-hot FSM encoding, the BCD digit width and significant-digit counting.
package bin2bcd_pkg;

    localparam int unsigned BCD_DIG_W  = 4;
    localparam int unsigned MAX_DIGITS = 32;
    localparam int unsigned MAX_BCD_W  = MAX_DIGITS * BCD_DIG_W;

    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StShift = 3'b010,
        StWait  = 3'b100
    } state_e;

    function automatic int unsigned clog2(input int unsigned val);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (val > 0) ? val - 1 : 0;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

    // Index of the highest nonzero digit plus one; an all-zero value still counts as one digit.
    function automatic int unsigned bcd_ndig(input logic [MAX_BCD_W-1:0] bcd,
                                             input int unsigned digits);
        int unsigned n;
        n = 1;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && bcd[i*BCD_DIG_W +: BCD_DIG_W] != '0) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_conv_if.sv
// Handshake bundle for bin2bcd_conv: input word channel and BCD result channel.
// master is the producer/consumer side, slave is the converter.
interface bin2bcd_conv_if #(
    parameter int unsigned BIN_W  = 32,
    parameter int unsigned DIGITS = 10
);
    import bin2bcd_pkg::*;

    localparam int unsigned NDIG_W = clog2(DIGITS + 1);

    logic                        in_vld;
    logic                        in_rdy;
    logic [BIN_W-1:0]            in_data;
    logic                        in_signed;
    logic                        out_vld;
    logic                        out_rdy;
    logic [DIGITS*BCD_DIG_W-1:0] out_bcd;
    logic                        out_neg;
    logic                        out_ovf;
    logic [NDIG_W-1:0]           out_ndig;
    logic                        busy;

    modport master (
        output in_vld, in_data, in_signed, out_rdy,
        input  in_rdy, out_vld, out_bcd, out_neg, out_ovf, out_ndig, busy
    );

    modport slave (
        input  in_vld, in_data, in_signed, out_rdy,
        output in_rdy, out_vld, out_bcd, out_neg, out_ovf, out_ndig, busy
    );

endinterface

// File: rtl/bcd_dabble_step.sv
// One combinational shift-and-add-3 step across DIGITS BCD digits.
// Digits above 4 get +3, then the whole accumulator shifts left taking shift_in at bit 0.
module bcd_dabble_step
    import bin2bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 10
) (
    input  logic [DIGITS*BCD_DIG_W-1:0] bcd_in,
    input  logic                        shift_in,
    output logic [DIGITS*BCD_DIG_W-1:0] bcd_out,
    output logic                        carry_out
);

    logic [DIGITS*BCD_DIG_W-1:0] adj;

    always_comb begin
        adj = bcd_in;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*BCD_DIG_W +: BCD_DIG_W] > 4'd4) begin
                adj[i*BCD_DIG_W +: BCD_DIG_W] = bcd_in[i*BCD_DIG_W +: BCD_DIG_W] + 4'd3;
            end
        end
    end

    assign {carry_out, bcd_out} = {adj, shift_in};

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential binary-to-BCD converter with optional signed input, SPC steps per clock,
// valid/ready on both sides, overflow flag and significant-digit count.
module bin2bcd_conv
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W     = 32,
    parameter int unsigned DIGITS    = 10,
    parameter int unsigned SIGNED_EN = 1,
    parameter int unsigned SPC       = 1
) (
    input logic           Clk,
    input logic           Rst_n,
    bin2bcd_conv_if.slave conv
);

    localparam int unsigned BCD_W    = DIGITS * BCD_DIG_W;
    localparam int unsigned STEPS    = BIN_W / SPC;
    localparam int unsigned CNT_W    = (clog2(STEPS) > 0) ? clog2(STEPS) : 1;
    localparam int unsigned NDIG_W   = clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    if (BIN_W < 4) begin : g_err_bin_w
        $error("bin2bcd_conv: BIN_W must be at least 4");
    end
    if (SPC < 1 || SPC > BIN_W || (BIN_W % SPC) != 0) begin : g_err_spc
        $error("bin2bcd_conv: SPC must divide BIN_W");
    end
    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_err_digits
        $error("bin2bcd_conv: DIGITS out of range");
    end

    state_e            state_q, state_d;
    logic [BIN_W-1:0]  mag_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic              ovf_q;
    logic              accept;
    logic              shifting;
    logic              load_out;
    logic              in_neg;

    logic              out_vld_q;
    logic [BCD_W-1:0]  out_bcd_q;
    logic              out_neg_q;
    logic              out_ovf_q;
    logic [NDIG_W-1:0] out_ndig_q;
    logic [MAX_BCD_W-1:0] bcd_pad;

    logic [BCD_W-1:0]  chain_bcd [SPC+1];
    logic [SPC-1:0]    chain_carry;

    // Step k consumes the k-th magnitude bit from the top within this clock.
    assign chain_bcd[0] = bcd_q;
    for (genvar k = 0; k < SPC; k++) begin : g_step
        bcd_dabble_step #(
            .DIGITS (DIGITS)
        ) u_step (
            .bcd_in    (chain_bcd[k]),
            .shift_in  (mag_q[BIN_W-1-k]),
            .bcd_out   (chain_bcd[k+1]),
            .carry_out (chain_carry[k])
        );
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (conv.in_vld) state_d = StShift;
            StShift: if (cnt_q == CNT_LAST) state_d = StWait;
            StWait:  if (!out_vld_q || conv.out_rdy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        accept      = 1'b0;
        shifting    = 1'b0;
        load_out    = 1'b0;
        conv.in_rdy = 1'b0;
        conv.busy   = 1'b1;
        unique case (state_q)
            StIdle: begin
                accept      = conv.in_vld;
                conv.in_rdy = 1'b1;
                conv.busy   = 1'b0;
            end
            StShift: shifting = 1'b1;
            StWait:  load_out = !out_vld_q || conv.out_rdy;
            default: ;
        endcase
    end

    // A set sign bit implies a nonzero word, so zero can never come out negative.
    assign in_neg = conv.in_signed && (SIGNED_EN != 0) && conv.in_data[BIN_W-1];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mag_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            mag_q <= in_neg ? -conv.in_data : conv.in_data;
            bcd_q <= '0;
            cnt_q <= '0;
            neg_q <= in_neg;
            ovf_q <= 1'b0;
        end else if (shifting) begin
            mag_q <= mag_q << SPC;
            bcd_q <= chain_bcd[SPC];
            cnt_q <= cnt_q + 1'b1;
            ovf_q <= ovf_q | (|chain_carry);
        end
    end

    always_comb begin
        bcd_pad            = '0;
        bcd_pad[BCD_W-1:0] = bcd_q;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_vld_q  <= 1'b0;
            out_bcd_q  <= '0;
            out_neg_q  <= 1'b0;
            out_ovf_q  <= 1'b0;
            out_ndig_q <= '0;
        end else if (load_out) begin
            out_vld_q  <= 1'b1;
            out_bcd_q  <= bcd_q;
            out_neg_q  <= neg_q;
            out_ovf_q  <= ovf_q;
            out_ndig_q <= NDIG_W'(bcd_ndig(bcd_pad, DIGITS));
        end else if (out_vld_q && conv.out_rdy) begin
            out_vld_q <= 1'b0;
        end
    end

    assign conv.out_vld  = out_vld_q;
    assign conv.out_bcd  = out_bcd_q;
    assign conv.out_neg  = out_neg_q;
    assign conv.out_ovf  = out_ovf_q;
    assign conv.out_ndig = out_ndig_q;

endmodule
